stopwatch_time_ctrl: RTL and testbench

//  Timebase and time-count sequencer for the stopwatch. Consumes the run/clear levels

---
 rtl/stopwatch_time_ctrl.sv | 108 ++++++++++
 tb/tb_stopwatch_time_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_ctrl.sv
// stopwatch_time_ctrl: centisecond timebase and mm:ss.cc counter with lap hold for the stopwatch display
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   i_run      - level, 1 = time advances
//   i_clear    - level, 1 = hold counters at zero
//   i_lap      - 1-cycle pulse, toggles lap hold in RUN/LAP
//   o_csec     - displayed centiseconds 0..99
//   o_sec      - displayed seconds 0..59
//   o_min      - displayed minutes 0..59
//   o_tick     - 1-cycle pulse on every counted centisecond
//   o_lap_hold - display frozen at captured lap time
//   o_wrap     - 1-cycle pulse after 59:59.99 -> 00:00.00
module stopwatch_time_ctrl #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_run,
    input  logic       i_clear,
    input  logic       i_lap,
    output logic [6:0] o_csec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic       o_tick,
    output logic       o_lap_hold,
    output logic       o_wrap
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {ZERO = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;

    state_t        state, nxt;
    logic [PW-1:0] presc;
    logic [6:0]    live_csec, lap_csec;
    logic [5:0]    live_sec, live_min, lap_sec, lap_min;
    logic          counting, tick, roll_c, roll_s, roll_m;

    always_comb begin
        nxt = ZERO;
        case (state)
            ZERO:    nxt = (!i_clear && i_run) ? RUN : ZERO;
            RUN:     nxt = i_clear ? ZERO : !i_run ? PAUSE : i_lap ? LAP : RUN;
            LAP:     nxt = i_clear ? ZERO : !i_run ? PAUSE : i_lap ? RUN : LAP;
            PAUSE:   nxt = i_clear ? ZERO : i_run ? RUN : PAUSE;
            default: nxt = ZERO;
        endcase
    end

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PW'(DIV - 1));
    assign roll_c   = live_csec == 7'd99;
    assign roll_s   = live_sec == 6'd59;
    assign roll_m   = live_min == 6'd59;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ZERO;
            presc     <= '0;
            live_csec <= '0;
            live_sec  <= '0;
            live_min  <= '0;
            lap_csec  <= '0;
            lap_sec   <= '0;
            lap_min   <= '0;
            o_wrap    <= 1'b0;
        end else begin
            state  <= nxt;
            o_wrap <= 1'b0;
            if (nxt == ZERO) begin
                presc     <= '0;
                live_csec <= '0;
                live_sec  <= '0;
                live_min  <= '0;
                lap_csec  <= '0;
                lap_sec   <= '0;
                lap_min   <= '0;
            end else begin
                // PAUSE keeps the partial period so a resume finishes it
                if (counting)
                    presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    live_csec <= roll_c ? 7'd0 : live_csec + 7'd1;
                    if (roll_c) begin
                        live_sec <= roll_s ? 6'd0 : live_sec + 6'd1;
                        if (roll_s)
                            live_min <= roll_m ? 6'd0 : live_min + 6'd1;
                    end
                    o_wrap <= roll_c && roll_s && roll_m;
                end
                // capture uses the pre-increment value when a tick lands on the same edge
                if (state == RUN && nxt == LAP) begin
                    lap_csec <= live_csec;
                    lap_sec  <= live_sec;
                    lap_min  <= live_min;
                end
            end
        end
    end

    assign o_tick     = tick;
    assign o_lap_hold = state == LAP;
    assign o_csec     = o_lap_hold ? lap_csec : live_csec;
    assign o_sec      = o_lap_hold ? lap_sec : live_sec;
    assign o_min      = o_lap_hold ? lap_min : live_min;
endmodule

// File: tb/tb_stopwatch_time_ctrl.sv
// tb_stopwatch_time_ctrl: directed self-checking bench for stopwatch_time_ctrl at DIV=10
module tb_stopwatch_time_ctrl;
    logic       clk = 1'b0, reset_n = 1'b0, i_run = 1'b0, i_clear = 1'b0, i_lap = 1'b0;
    logic [6:0] o_csec;
    logic [5:0] o_sec, o_min;
    logic       o_tick, o_lap_hold, o_wrap;
    int         checks = 0, failures = 0, tick_cnt = 0, wrap_cnt = 0;

    stopwatch_time_ctrl #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_clear(i_clear), .i_lap(i_lap),
        .o_csec(o_csec), .o_sec(o_sec), .o_min(o_min), .o_tick(o_tick),
        .o_lap_hold(o_lap_hold), .o_wrap(o_wrap)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (o_tick) tick_cnt++;
        if (o_wrap) wrap_cnt++;
    endtask

    task automatic test_reset();
        int bad;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({o_min, o_sec, o_csec, o_tick, o_lap_hold, o_wrap} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h expected 0", {o_min, o_sec, o_csec, o_tick, o_lap_hold, o_wrap});
        end
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if ({o_min, o_sec, o_csec, o_tick, o_lap_hold, o_wrap} !== 22'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_zero got %0d nonzero cycles expected 0", bad);
        end
    endtask

    task automatic test_run();
        int first;
        first = 0;
        tick_cnt = 0;
        i_run = 1'b1;
        for (int i = 1; i <= 1000; i++) begin
            step();
            if (o_tick && first == 0) first = i;
        end
        checks++;
        if (tick_cnt !== 100) begin
            failures++;
            $display("FAIL run_ticks got %0d expected 100", tick_cnt);
        end
        checks++;
        if (first !== 10) begin
            failures++;
            $display("FAIL first_tick got cycle %0d expected 10", first);
        end
        i_run = 1'b0;
        step();
        checks++;
        if ({o_min, o_sec, o_csec} !== {6'd0, 6'd1, 7'd0}) begin
            failures++;
            $display("FAIL run_display got %0d:%0d.%0d expected 0:1.0", o_min, o_sec, o_csec);
        end
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        checks++;
        if ({o_min, o_sec, o_csec} !== 19'd0) begin
            failures++;
            $display("FAIL clear_after_run got %0d:%0d.%0d expected 0:0.0", o_min, o_sec, o_csec);
        end
    endtask

    task automatic test_pause();
        i_run = 1'b1;
        repeat (25) step();
        i_run = 1'b0;
        tick_cnt = 0;
        repeat (50) step();
        checks++;
        if (tick_cnt !== 0 || o_csec !== 7'd2) begin
            failures++;
            $display("FAIL pause_hold got ticks=%0d csec=%0d expected ticks=0 csec=2", tick_cnt, o_csec);
        end
        i_run = 1'b1;
        repeat (5) step();
        i_run = 1'b0;
        step();
        checks++;
        if ({o_min, o_sec, o_csec} !== {6'd0, 6'd0, 7'd3}) begin
            failures++;
            $display("FAIL pause_resume got %0d:%0d.%0d expected 0:0.3", o_min, o_sec, o_csec);
        end
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
    endtask

    task automatic test_wrap();
        i_run = 1'b1;
        step();
        i_run = 1'b0;
        step();
        force dut.live_csec = 7'd98;
        force dut.live_sec  = 6'd59;
        force dut.live_min  = 6'd59;
        step();
        release dut.live_csec;
        release dut.live_sec;
        release dut.live_min;
        step();
        checks++;
        if ({o_min, o_sec, o_csec} !== {6'd59, 6'd59, 7'd98}) begin
            failures++;
            $display("FAIL preload got %0d:%0d.%0d expected 59:59.98", o_min, o_sec, o_csec);
        end
        tick_cnt = 0;
        wrap_cnt = 0;
        i_run = 1'b1;
        repeat (20) step();
        checks++;
        if ({o_min, o_sec, o_csec} !== 19'd0 || o_wrap !== 1'b1) begin
            failures++;
            $display("FAIL rollover got %0d:%0d.%0d wrap=%b expected 0:0.0 wrap=1", o_min, o_sec, o_csec, o_wrap);
        end
        i_run = 1'b0;
        step();
        checks++;
        if (wrap_cnt !== 1 || tick_cnt !== 2 || o_wrap !== 1'b0) begin
            failures++;
            $display("FAIL wrap_pulse got wraps=%0d ticks=%0d wrap=%b expected 1 2 0", wrap_cnt, tick_cnt, o_wrap);
        end
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
    endtask

    task automatic test_lap();
        i_run = 1'b1;
        repeat (401) step();
        checks++;
        if ({o_min, o_sec, o_csec, o_lap_hold} !== {6'd0, 6'd0, 7'd40, 1'b0}) begin
            failures++;
            $display("FAIL lap_pre got %0d:%0d.%0d hold=%b expected 0:0.40 hold=0", o_min, o_sec, o_csec, o_lap_hold);
        end
        i_lap = 1'b1;
        step();
        i_lap = 1'b0;
        repeat (300) step();
        checks++;
        if ({o_min, o_sec, o_csec, o_lap_hold} !== {6'd0, 6'd0, 7'd40, 1'b1}) begin
            failures++;
            $display("FAIL lap_frozen got %0d:%0d.%0d hold=%b expected 0:0.40 hold=1", o_min, o_sec, o_csec, o_lap_hold);
        end
        repeat (299) step();
        i_lap = 1'b1;
        step();
        i_lap = 1'b0;
        checks++;
        if ({o_min, o_sec, o_csec, o_lap_hold} !== {6'd0, 6'd1, 7'd0, 1'b0}) begin
            failures++;
            $display("FAIL lap_release got %0d:%0d.%0d hold=%b expected 0:1.0 hold=0", o_min, o_sec, o_csec, o_lap_hold);
        end
    endtask

    task automatic test_clear();
        int bad;
        i_lap = 1'b1;
        step();
        i_lap = 1'b0;
        i_clear = 1'b1;
        step();
        checks++;
        if ({o_min, o_sec, o_csec, o_tick, o_lap_hold, o_wrap} !== 22'd0) begin
            failures++;
            $display("FAIL clear_in_lap got %h expected 0", {o_min, o_sec, o_csec, o_tick, o_lap_hold, o_wrap});
        end
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if ({o_min, o_sec, o_csec, o_tick, o_lap_hold} !== 20'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL run_and_clear got %0d nonzero cycles expected 0", bad);
        end
        i_clear = 1'b0;
        repeat (10) step();
        checks++;
        if (o_tick !== 1'b1) begin
            failures++;
            $display("FAIL tick_before_clear got %b expected 1", o_tick);
        end
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        i_run = 1'b0;
        checks++;
        if ({o_min, o_sec, o_csec, o_tick, o_lap_hold, o_wrap} !== 22'd0) begin
            failures++;
            $display("FAIL clear_on_tick got %h expected 0", {o_min, o_sec, o_csec, o_tick, o_lap_hold, o_wrap});
        end
        step();
    endtask

    task automatic test_async_reset();
        i_run = 1'b1;
        repeat (37) step();
        checks++;
        if (o_csec !== 7'd3) begin
            failures++;
            $display("FAIL pre_reset_count got %0d expected 3", o_csec);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({o_min, o_sec, o_csec, o_tick, o_lap_hold, o_wrap} !== 22'd0) begin
            failures++;
            $display("FAIL async_reset got %h expected 0", {o_min, o_sec, o_csec, o_tick, o_lap_hold, o_wrap});
        end
        i_run = 1'b0;
        #3 reset_n = 1'b1;
        step();
        checks++;
        if ({o_min, o_sec, o_csec, o_tick} !== 20'd0) begin
            failures++;
            $display("FAIL post_reset got %h expected 0", {o_min, o_sec, o_csec, o_tick});
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_wrap();
        test_lap();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
